// File: rtl/sampler_pkg.sv
// Shared constants, record types and helpers for the lease-cache reuse sampler.
package sampler_pkg;

  localparam int N_WAY      = 8;
  localparam int WAY_W      = 3;
  localparam int TAG_W_DEF  = 26;
  localparam int PC_W_DEF   = 32;
  localparam int TIME_W_DEF = 32;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [PC_W_DEF-1:0]   pc;
    logic [TIME_W_DEF-1:0] stamp;
  } entry_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [TIME_W_DEF-1:0] reuse;
    logic                  expired;
  } report_t;

  // Index of the lowest set bit; zero when no bit is set.
  function automatic logic [WAY_W-1:0] lowest_set(input logic [N_WAY-1:0] vec);
    logic [WAY_W-1:0] idx;
    idx = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = WAY_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/sampler_free_way_finder.sv
// Combinational lowest-free-way finder over the per-way valid bits.
module sampler_free_way_finder
  import sampler_pkg::*;
(
  input  logic [N_WAY-1:0] valid,
  output logic [WAY_W-1:0] free_idx,
  output logic             any_free
);

  // Lowest invalid way and whether any way is free.
  always_comb begin
    free_idx = lowest_set(~valid);
    any_free = ~(&valid);
  end

endmodule

// File: rtl/sampler_tag_buffer.sv
// Eight-entry fully-associative reuse sample buffer with a one-deep report register.
// Optional feature macro: SAMPLER_EXPIRE_REPORT_EN (report full-buffer evictions as expired).
module sampler_tag_buffer
  import sampler_pkg::*;
#(
  parameter int TAG_W  = TAG_W_DEF,
  parameter int PC_W   = PC_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              ref_valid_i,
  output logic              ref_ready_o,
  input  logic [TAG_W-1:0]  ref_tag_i,
  input  logic [PC_W-1:0]   ref_pc_i,
  input  logic              ref_sample_i,
  output logic              rpt_valid_o,
  input  logic              rpt_ready_i,
  output logic [PC_W-1:0]   rpt_pc_o,
  output logic [TIME_W-1:0] rpt_reuse_o,
  output logic              rpt_expired_o,
  output logic [3:0]        occupancy_o,
  output logic [TIME_W-1:0] time_o
);

  logic [N_WAY-1:0]  valid_r;
  logic [TAG_W-1:0]  tag_r   [N_WAY];
  logic [PC_W-1:0]   pc_r    [N_WAY];
  logic [TIME_W-1:0] stamp_r [N_WAY];
  logic [WAY_W-1:0]  vp_r;
  logic [3:0]        occupancy_r;
  logic [TIME_W-1:0] time_r;

  logic              stage_valid_r;
  logic [TAG_W-1:0]  stage_tag_r;
  logic [PC_W-1:0]   stage_pc_r;
  logic              stage_sample_r;
  logic [TIME_W-1:0] stage_stamp_r;

  logic              rpt_valid_r;
  logic [PC_W-1:0]   rpt_pc_r;
  logic [TIME_W-1:0] rpt_reuse_r;
  logic              rpt_expired_r;

  logic [N_WAY-1:0]  match_s;
  logic              hit_s;
  logic [WAY_W-1:0]  hit_way_s;
  logic [WAY_W-1:0]  free_way_s;
  logic              any_free_s;
  logic              advance_s;
  logic              accept_s;
  logic              evict_s;
  logic              rpt_load_s;
  logic [PC_W-1:0]   rpt_pc_s;
  logic [TIME_W-1:0] rpt_reuse_s;
  logic              rpt_expired_s;

  sampler_free_way_finder u_free (
    .valid    (valid_r),
    .free_idx (free_way_s),
    .any_free (any_free_s)
  );

  // Associative compare of the staged tag against every valid way.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < N_WAY; i++) begin
      match_s[i] = valid_r[i] && (tag_r[i] == stage_tag_r);
    end
  end

  assign hit_s       = |match_s;
  assign hit_way_s   = lowest_set(match_s);
  assign advance_s   = stage_valid_r && (!rpt_valid_r || rpt_ready_i);
  assign ref_ready_o = !stage_valid_r || advance_s;
  assign accept_s    = ref_valid_i && ref_ready_o;
  assign evict_s     = !hit_s && stage_sample_r && !any_free_s;

  // Next report contents: reuse on a hit, optionally expiry on an eviction.
  always_comb begin
    rpt_load_s    = 1'b0;
    rpt_pc_s      = pc_r[hit_way_s];
    rpt_reuse_s   = stage_stamp_r - stamp_r[hit_way_s];
    rpt_expired_s = 1'b0;
    if (hit_s) begin
      rpt_load_s = advance_s;
    end else if (evict_s) begin
`ifdef SAMPLER_EXPIRE_REPORT_EN
      rpt_load_s    = advance_s;
      rpt_pc_s      = pc_r[vp_r];
      rpt_reuse_s   = stage_stamp_r - stamp_r[vp_r];
      rpt_expired_s = 1'b1;
`else
      rpt_load_s    = 1'b0;
`endif
    end else begin
      rpt_load_s = 1'b0;
    end
  end

  // Reference intake: stage register and global reference counter.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      stage_valid_r  <= 1'b0;
      stage_tag_r    <= '0;
      stage_pc_r     <= '0;
      stage_sample_r <= 1'b0;
      stage_stamp_r  <= '0;
      time_r         <= '0;
    end else if (accept_s) begin
      stage_valid_r  <= 1'b1;
      stage_tag_r    <= ref_tag_i;
      stage_pc_r     <= ref_pc_i;
      stage_sample_r <= ref_sample_i;
      stage_stamp_r  <= time_r;
      time_r         <= time_r + TIME_W'(1);
    end else if (advance_s) begin
      stage_valid_r  <= 1'b0;
    end
  end

  // Table update in the execute cycle; only the lowest matching way is touched.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < N_WAY; i++) begin
        tag_r[i]   <= '0;
        pc_r[i]    <= '0;
        stamp_r[i] <= '0;
      end
      valid_r     <= '0;
      vp_r        <= '0;
      occupancy_r <= 4'd0;
    end else if (advance_s) begin
      if (hit_s) begin
        if (stage_sample_r) begin
          tag_r[hit_way_s]   <= stage_tag_r;
          pc_r[hit_way_s]    <= stage_pc_r;
          stamp_r[hit_way_s] <= stage_stamp_r;
        end else begin
          valid_r[hit_way_s] <= 1'b0;
          occupancy_r        <= occupancy_r - 4'd1;
        end
      end else if (stage_sample_r && any_free_s) begin
        valid_r[free_way_s] <= 1'b1;
        tag_r[free_way_s]   <= stage_tag_r;
        pc_r[free_way_s]    <= stage_pc_r;
        stamp_r[free_way_s] <= stage_stamp_r;
        occupancy_r         <= occupancy_r + 4'd1;
      end else if (stage_sample_r) begin
        tag_r[vp_r]   <= stage_tag_r;
        pc_r[vp_r]    <= stage_pc_r;
        stamp_r[vp_r] <= stage_stamp_r;
        vp_r          <= vp_r + WAY_W'(1);
      end
    end
  end

  // Report register: a new report wins over a same-cycle drain.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rpt_valid_r   <= 1'b0;
      rpt_pc_r      <= '0;
      rpt_reuse_r   <= '0;
      rpt_expired_r <= 1'b0;
    end else if (rpt_load_s) begin
      rpt_valid_r   <= 1'b1;
      rpt_pc_r      <= rpt_pc_s;
      rpt_reuse_r   <= rpt_reuse_s;
      rpt_expired_r <= rpt_expired_s;
    end else if (rpt_ready_i) begin
      rpt_valid_r   <= 1'b0;
    end
  end

  assign rpt_valid_o   = rpt_valid_r;
  assign rpt_pc_o      = rpt_pc_r;
  assign rpt_reuse_o   = rpt_reuse_r;
  assign rpt_expired_o = rpt_expired_r;
  assign occupancy_o   = occupancy_r;
  assign time_o        = time_r;

endmodule

// File: tb/tb_sampler_tag_buffer.sv
// Directed bench for sampler_tag_buffer: vector table plus hand sequences for backpressure, wrap and reset.
module tb_sampler_tag_buffer;

`ifdef SAMPLER_EXPIRE_REPORT_EN
  localparam logic EXP_EN = 1'b1;
`else
  localparam logic EXP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ref_valid = 1'b0;
  logic        ref_ready;
  logic [25:0] ref_tag = '0;
  logic [31:0] ref_pc = '0;
  logic        ref_sample = 1'b0;
  logic        rpt_valid;
  logic        rpt_ready = 1'b1;
  logic [31:0] rpt_pc;
  logic [31:0] rpt_reuse;
  logic        rpt_expired;
  logic [3:0]  occ;
  logic [31:0] tim;

  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [25:0] w_tag = '0;
  logic [31:0] w_pc = '0;
  logic        w_sample = 1'b0;
  logic        w_rpt_valid;
  logic [31:0] w_rpt_pc;
  logic [3:0]  w_rpt_reuse;
  logic        w_rpt_expired;
  logic [3:0]  w_occ;
  logic [3:0]  w_time;

  always #5 clk = ~clk;

  sampler_tag_buffer dut (
    .clock_i(clk), .resetn_i(rst_n),
    .ref_valid_i(ref_valid), .ref_ready_o(ref_ready), .ref_tag_i(ref_tag),
    .ref_pc_i(ref_pc), .ref_sample_i(ref_sample),
    .rpt_valid_o(rpt_valid), .rpt_ready_i(rpt_ready), .rpt_pc_o(rpt_pc),
    .rpt_reuse_o(rpt_reuse), .rpt_expired_o(rpt_expired),
    .occupancy_o(occ), .time_o(tim)
  );

  sampler_tag_buffer #(.TIME_W(4)) dut_w (
    .clock_i(clk), .resetn_i(rst_n),
    .ref_valid_i(w_valid), .ref_ready_o(w_ready), .ref_tag_i(w_tag),
    .ref_pc_i(w_pc), .ref_sample_i(w_sample),
    .rpt_valid_o(w_rpt_valid), .rpt_ready_i(1'b1), .rpt_pc_o(w_rpt_pc),
    .rpt_reuse_o(w_rpt_reuse), .rpt_expired_o(w_rpt_expired),
    .occupancy_o(w_occ), .time_o(w_time)
  );

  typedef struct {
    logic [25:0] tag;
    logic [31:0] pc;
    logic        smp;
    logic        rv;
    logic [31:0] epc;
    logic [31:0] ereuse;
    logic        eexp;
    logic [3:0]  eocc;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic add(input logic [25:0] tag, input logic [31:0] pc, input logic smp,
                     input logic rv, input logic [31:0] epc, input logic [31:0] ereuse,
                     input logic eexp, input logic [3:0] eocc);
    vecs[nvec] = '{tag, pc, smp, rv, epc, ereuse, eexp, eocc};
    nvec++;
  endtask

  task automatic filler(input int n, input logic [3:0] eocc);
    for (int i = 0; i < n; i++) add(26'h999, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, eocc);
  endtask

  // Offer one reference at a falling edge; wait (bounded) for ready, then accept.
  task automatic offer(input logic [25:0] tag, input logic [31:0] pc, input logic smp);
    int n;
    n = 0;
    @(negedge clk);
    ref_valid = 1'b1; ref_tag = tag; ref_pc = pc; ref_sample = smp;
    while (!ref_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk_cnt++;
      $display("FAIL offer_timeout: got ref_ready=0 expected 1 within 20 cycles");
    end
    @(posedge clk);
    #1;
    ref_valid = 1'b0;
  endtask

  initial begin
    // Vector table: reference k is accepted at time k.
    add(26'h100, 32'hA0, 1'b1, 1'b0, 32'h0,  32'd0, 1'b0, 4'd1);
    filler(4, 4'd1);
    add(26'h100, 32'h0,  1'b0, 1'b1, 32'hA0, 32'd5, 1'b0, 4'd0);
    add(26'h005, 32'h55, 1'b1, 1'b0, 32'h0,  32'd0, 1'b0, 4'd1);
    filler(6, 4'd1);
    add(26'h005, 32'h66, 1'b1, 1'b1, 32'h55, 32'd7, 1'b0, 4'd1);
    filler(2, 4'd1);
    add(26'h005, 32'h77, 1'b0, 1'b1, 32'h66, 32'd3, 1'b0, 4'd0);
    for (int i = 0; i < 8; i++)
      add(26'h200 + 26'(i), 32'h300 + 32'(i), 1'b1, 1'b0, 32'h0, 32'd0, 1'b0, 4'(i + 1));
    add(26'h2FF, 32'h3FF, 1'b1, EXP_EN, 32'h300, 32'd8, 1'b1, 4'd8);
    add(26'h2FE, 32'h3FE, 1'b1, EXP_EN, 32'h301, 32'd8, 1'b1, 4'd8);
    add(26'h200, 32'h0,   1'b0, 1'b0,   32'h0,   32'd0, 1'b0, 4'd8);
    add(26'h2FF, 32'h0,   1'b0, 1'b1,   32'h3FF, 32'd3, 1'b0, 4'd7);
    add(26'h201, 32'h0,   1'b0, 1'b0,   32'h0,   32'd0, 1'b0, 4'd7);
    add(26'h202, 32'h0,   1'b0, 1'b1,   32'h302, 32'd11, 1'b0, 4'd6);

    #12;
    chk("rst_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("rst_rpt_pc", 64'(rpt_pc), 64'd0);
    chk("rst_rpt_reuse", 64'(rpt_reuse), 64'd0);
    chk("rst_rpt_expired", 64'(rpt_expired), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_time", 64'(tim), 64'd0);
    chk("rst_ref_ready", 64'(ref_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < nvec; k++) begin
      offer(vecs[k].tag, vecs[k].pc, vecs[k].smp);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_rpt_valid", k), 64'(rpt_valid), 64'(vecs[k].rv));
      if (vecs[k].rv) begin
        chk($sformatf("v%0d_rpt_pc", k), 64'(rpt_pc), 64'(vecs[k].epc));
        chk($sformatf("v%0d_rpt_reuse", k), 64'(rpt_reuse), 64'(vecs[k].ereuse));
        chk($sformatf("v%0d_rpt_expired", k), 64'(rpt_expired), 64'(vecs[k].eexp));
      end
      chk($sformatf("v%0d_occ", k), 64'(occ), 64'(vecs[k].eocc));
      chk($sformatf("v%0d_time", k), 64'(tim), 64'(k + 1));
    end
    @(posedge clk);
    #1;
    chk("drain_rpt_valid", 64'(rpt_valid), 64'd0);

    // Backpressure: two hits while the consumer stalls.
    @(negedge clk);
    rpt_ready = 1'b0;
    offer(26'h500, 32'h51, 1'b1);
    offer(26'h500, 32'h52, 1'b1);
    offer(26'h500, 32'h53, 1'b0);
    @(negedge clk);
    chk("bp_ref_ready", 64'(ref_ready), 64'd0);
    chk("bp_rpt_valid", 64'(rpt_valid), 64'd1);
    chk("bp_rpt_pc", 64'(rpt_pc), 64'h51);
    chk("bp_rpt_reuse", 64'(rpt_reuse), 64'd1);
    repeat (3) @(negedge clk);
    chk("bp_hold_ready", 64'(ref_ready), 64'd0);
    chk("bp_hold_pc", 64'(rpt_pc), 64'h51);
    chk("bp_time", 64'(tim), 64'd34);
    rpt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_second_valid", 64'(rpt_valid), 64'd1);
    chk("bp_second_pc", 64'(rpt_pc), 64'h52);
    chk("bp_second_reuse", 64'(rpt_reuse), 64'd1);
    @(posedge clk);
    #1;
    chk("bp_drained", 64'(rpt_valid), 64'd0);
    chk("bp_occ", 64'(occ), 64'd6);
    chk("bp_ready_back", 64'(ref_ready), 64'd1);

    // Asynchronous reset with a pending report.
    @(negedge clk);
    rpt_ready = 1'b0;
    offer(26'h700, 32'h70, 1'b1);
    offer(26'h700, 32'h71, 1'b0);
    @(posedge clk);
    #1;
    chk("ar_pending", 64'(rpt_valid), 64'd1);
    chk("ar_pending_pc", 64'(rpt_pc), 64'h70);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rpt_valid", 64'(rpt_valid), 64'd0);
    chk("ar_occ", 64'(occ), 64'd0);
    chk("ar_time", 64'(tim), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rpt_ready = 1'b1;

    // Wrap on a 4-bit-time instance: sample at 14, hit 4 references later at 2.
    w_valid = 1'b1; w_tag = 26'h77; w_sample = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("wrap_time_pre", 64'(w_time), 64'd14);
    w_tag = 26'h33; w_pc = 32'hC3; w_sample = 1'b1;
    @(posedge clk);
    #1;
    w_tag = 26'h77; w_sample = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    w_tag = 26'h33;
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("wrap_rpt_valid", 64'(w_rpt_valid), 64'd1);
    chk("wrap_rpt_pc", 64'(w_rpt_pc), 64'hC3);
    chk("wrap_rpt_reuse", 64'(w_rpt_reuse), 64'd4);
    chk("wrap_time", 64'(w_time), 64'd3);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/sampler_tag_buffer.md
# sampler_tag_buffer

Eight-entry fully-associative sample buffer for the lease-cache reuse sampler. It holds sampled block tags with their reference PC and the timestamp at which each was sampled. Every incoming reference is compared against all valid tags. A hit emits a reuse-interval report (stored PC, elapsed references) to the lease-statistics stage. The block generates the 8-bit per-way match vector internally and reduces it to a 3-bit way index plus a hit flag.

## Interface
- TAG_W, 26, block-tag width
- PC_W, 32, reference-PC width
- TIME_W, 32, timestamp/reuse width; wraps modulo 2^TIME_W
- clock_i  in  1  sole clock, rising edge
- resetn_i  in  1  asynchronous, active-low reset
- ref_valid_i  in  1  reference offered
- ref_ready_o  out  1  reference accepted when valid&ready
- ref_tag_i  in  TAG_W  block tag of reference
- ref_pc_i  in  PC_W  PC of reference
- ref_sample_i  in  1  reference is selected for sampling
- rpt_valid_o  out  1  report register full
- rpt_ready_i  in  1  consumer takes report when valid&ready
- rpt_pc_o  out  PC_W  PC stored with matched/evicted entry
- rpt_reuse_o  out  TIME_W  current time minus stored timestamp
- rpt_expired_o  out  1  report is an eviction, not a reuse
- occupancy_o  out  4  count of valid entries, 0..8
- time_o  out  TIME_W  global reference counter

## Operation
- Per-entry state: valid, tag, pc, stamp.
- Accepted reference loads the stage register with tag, pc, sample, and stamp=time. Time increments by 1 on acceptance.
- Execute cycle (stage register valid and advancing) compares the staged tag against all 8 valid entries to form match[7:0].
- Way index is the lowest set bit; hit = |match.
- Hit: load report {pc[way], time_at_stage − stamp[way] mod 2^TIME_W, expired=0}. Then:
  - sample=1: rewrite way with staged tag/pc/stamp (occupancy unchanged).
  - sample=0: clear valid[way] (occupancy −1).
  - Only the lowest matching way is touched; higher duplicate matches are left unchanged.
- Miss, sample=1, free way exists: write the lowest-index invalid way (occupancy +1). No report.
- Miss, sample=1, buffer full: overwrite the way at round-robin victim pointer vp (3-bit, wraps 7→0), then vp+1. Eviction report per configuration.
- Miss, sample=0: no state change, no report.
- Report register holds until rpt_ready_i.
- Stage advances when report register is empty or drained this cycle. ref_ready_o = !stage_valid | advance.

## Timing
- Reset values: all valid=0, time_o=0, vp=0, stage empty, rpt_valid_o=0, rpt_pc_o=0, rpt_reuse_o=0, rpt_expired_o=0, occupancy_o=0, ref_ready_o=1.
- Reference accepted at edge N. Compare and table update occur in cycle N..N+1. Table and report are updated at edge N+1, so rpt_valid_o is high from N+1.
- Throughput: one reference per cycle while reports are drained each cycle.
- Back-to-back same tag: the second reference sees the table as updated by the first, because compare and write share the same execute cycle. No hazard.
- Report full with rpt_ready_i=0: stage holds and ref_ready_o=0. A held op that would not report still waits.
- Simultaneous drain and new report in the same cycle: the new report loads and rpt_valid_o stays 1.
- Time wrap 2^TIME_W−1→0: reuse uses modular subtraction and is correct for intervals < 2^TIME_W.
- Reset mid-operation: all state cleared asynchronously; the in-flight reference and pending report are discarded.

## Configuration
- SAMPLER_EXPIRE_REPORT_EN defined: a full-buffer eviction loads a report {victim pc, time − victim stamp, expired=1} and obeys report backpressure.
- Not defined: the victim is overwritten silently, rpt_expired_o is tied to 0, and evictions never stall.

## Structure
- Shared package sampler_pkg holds:
  - N_WAY=8 and WAY_W=3
  - default TAG_W/PC_W/TIME_W
  - the entry struct typedef {valid, tag, pc, stamp}
  - the report struct typedef {pc, reuse, expired}
- One sub-module, sampler_free_way_finder: combinational lowest-zero finder over valid[7:0] producing free index and any_free.

## Test plan
- Reset, then sample tag 0x100 pc 0xA0 at time 0; reference tag 0x100 (sample=0) at time 5 -> report pc 0xA0, reuse 5, expired 0, occupancy 1→0.
- Sample 8 distinct tags, then sample a 9th -> way 0 overwritten, vp=1, occupancy stays 8. With SAMPLER_EXPIRE_REPORT_EN: expired report reuse 8. Without: no report.
- Sample tag 0x5 at time 2, then hit with sample=1 at time 9 -> report reuse 7, entry restamped to 9. A later hit at time 12 -> reuse 3.
- Hold rpt_ready_i=0 with a pending report and issue 2 hits -> ref_ready_o=0 after the first staged op. Release -> reports emerge in order, none lost.
- Preset time to 0xFFFF_FFFE, sample; hit 4 references later -> reuse 4.
- Assert resetn_i low while a report is pending -> rpt_valid_o=0 and occupancy_o=0 immediately, without waiting for a clock edge.
